// File: rtl/multichannel_audio_parallelizer_if.sv
// Stream interface of the multichannel audio parallelizer: channel-tagged serial samples in,
// complete parallel frames out, both with valid/ready handshakes.
interface multichannel_audio_parallelizer_if #(
    parameter int unsigned audio_width = 32,
    parameter int unsigned channels    = 2
);
    localparam int unsigned cw = $clog2(channels);

    logic                            i_valid;
    logic                            i_ready;
    logic [cw-1:0]                   i_channel;
    logic [audio_width-1:0]          i_audio;
    logic                            o_valid;
    logic                            o_ready;
    logic [channels*audio_width-1:0] o_frame;
    logic                            o_sync_error;
    logic [15:0]                     o_drop_count;

    // Environment side: sample source and frame sink.
    modport master (
        output i_valid, i_channel, i_audio, o_ready,
        input  i_ready, o_valid, o_frame, o_sync_error, o_drop_count
    );

    // Parallelizer side.
    modport slave (
        input  i_valid, i_channel, i_audio, o_ready,
        output i_ready, o_valid, o_frame, o_sync_error, o_drop_count
    );
endinterface

// File: rtl/multichannel_audio_parallelizer.sv
// Assembles channel-tagged serial samples into parallel frames with order checking, resync on
// channel 0, and a one-frame holding slot so input keeps flowing while a frame waits downstream.
module multichannel_audio_parallelizer #(
    parameter int unsigned audio_width = 32,
    parameter int unsigned channels    = 2
) (
    input logic                              clk,
    input logic                              reset,
    multichannel_audio_parallelizer_if.slave bus
);
    localparam int unsigned   cw      = $clog2(channels);
    localparam logic [cw-1:0] last_ch = cw'(channels - 1);

    logic [channels-1:0][audio_width-1:0] asm_q, asm_d, asm_wr;
    logic [channels*audio_width-1:0]      frame_q, frame_d;
    logic [cw-1:0]                        exp_q, exp_d;
    logic                                 pending_q, pending_d;
    logic                                 o_valid_q, o_valid_d;
    logic                                 sync_q, sync_d;
    logic [15:0]                          drop_q, drop_d;
    logic                                 accept, in_order, drain, drop_inc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            asm_q     <= '0;
            frame_q   <= '0;
            exp_q     <= '0;
            pending_q <= 1'b0;
            o_valid_q <= 1'b0;
            sync_q    <= 1'b0;
            drop_q    <= '0;
        end else begin
            asm_q     <= asm_d;
            frame_q   <= frame_d;
            exp_q     <= exp_d;
            pending_q <= pending_d;
            o_valid_q <= o_valid_d;
            sync_q    <= sync_d;
            drop_q    <= drop_d;
        end
    end

    always_comb begin
        accept   = bus.i_valid && !pending_q;
        in_order = (bus.i_channel == exp_q);
        drain    = o_valid_q && bus.o_ready;
        // Assembly contents including the current in-order sample.
        asm_wr        = asm_q;
        asm_wr[exp_q] = bus.i_audio;
    end

    always_comb begin
        asm_d     = asm_q;
        frame_d   = frame_q;
        exp_d     = exp_q;
        pending_d = pending_q;
        o_valid_d = o_valid_q;
        sync_d    = 1'b0;
        drop_inc  = 1'b0;

        if (drain) begin
            if (pending_q) begin
                frame_d   = asm_q;
                pending_d = 1'b0;
            end else begin
                o_valid_d = 1'b0;
            end
        end

        // No accept can happen while pending, so this never collides with the pending drain.
        if (accept) begin
            if (in_order) begin
                asm_d = asm_wr;
                if (exp_q == last_ch) begin
                    exp_d = '0;
                    if (!o_valid_q || bus.o_ready) begin
                        frame_d   = asm_wr;
                        o_valid_d = 1'b1;
                    end else begin
                        pending_d = 1'b1;
                    end
                end else begin
                    exp_d = exp_q + cw'(1);
                end
            end else begin
                sync_d = 1'b1;
                if (bus.i_channel == '0) begin
                    asm_d[0] = bus.i_audio;
                    exp_d    = cw'(1);
                    drop_inc = (exp_q != '0);
                end else begin
                    exp_d    = '0;
                    drop_inc = 1'b1;
                end
            end
        end

        drop_d = (drop_inc && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
    end

    assign bus.i_ready      = !pending_q;
    assign bus.o_valid      = o_valid_q;
    assign bus.o_frame      = frame_q;
    assign bus.o_sync_error = sync_q;
    assign bus.o_drop_count = drop_q;
endmodule

// File: tb/tb_multichannel_audio_parallelizer.sv
// Scoreboard bench for the 4-channel, 16-bit parallelizer: directed scenarios plus random
// traffic, checked against a frame-level reference model.
module tb_multichannel_audio_parallelizer;
    localparam int unsigned AW = 16;
    localparam int unsigned CH = 4;

    logic clk;
    logic reset;

    multichannel_audio_parallelizer_if #(.audio_width(AW), .channels(CH)) bus ();

    multichannel_audio_parallelizer #(.audio_width(AW), .channels(CH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned handshakes = 0;

    // Reference model: expected channel, partial frame, completed frames awaiting handshake.
    logic [63:0]  q[$];
    logic [AW-1:0] part[CH];
    int           exp_ch = 0;
    logic [15:0]  exp_drop = 0;
    bit           exp_sync = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic bump_drop();
        if (exp_drop != 16'hFFFF) exp_drop = exp_drop + 16'd1;
    endtask

    task automatic model_accept(input int ch, input logic [AW-1:0] a);
        logic [63:0] f;
        if (ch == exp_ch) begin
            part[ch] = a;
            if (exp_ch == CH - 1) begin
                for (int k = 0; k < CH; k++) f[k*AW +: AW] = part[k];
                q.push_back(f);
                exp_ch = 0;
            end else begin
                exp_ch++;
            end
        end else begin
            exp_sync = 1'b1;
            if (ch == 0) begin
                part[0] = a;
                if (exp_ch != 0) bump_drop();
                exp_ch = 1;
            end else begin
                exp_ch = 0;
                bump_drop();
            end
        end
    endtask

    task automatic cyc(input bit v, input int ch, input logic [AW-1:0] a, input bit ordy);
        bit rdy_m;
        @(negedge clk);
        bus.i_valid   = v;
        bus.i_channel = 2'(ch);
        bus.i_audio   = a;
        bus.o_ready   = ordy;
        rdy_m = (q.size() < 2);
        @(posedge clk);
        exp_sync = 1'b0;
        if (v && rdy_m) model_accept(ch, a);
    endtask

    task automatic send_frame(input logic [63:0] f, input bit ordy);
        for (int k = 0; k < CH; k++) cyc(1'b1, k, f[k*AW +: AW], ordy);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.i_valid = 1'b0;
        bus.o_ready = 1'b0;
        q.delete();
        exp_ch = 0;
        exp_drop = '0;
        exp_sync = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: samples just before each rising edge, away from the active edge.
    always begin
        @(negedge clk);
        #4;
        if (reset) begin
            chk("reset_i_ready", 64'(bus.i_ready), 64'd1);
            chk("reset_o_valid", 64'(bus.o_valid), 64'd0);
            chk("reset_o_frame", bus.o_frame, 64'd0);
            chk("reset_sync", 64'(bus.o_sync_error), 64'd0);
            chk("reset_drop", 64'(bus.o_drop_count), 64'd0);
        end else begin
            chk("o_valid", 64'(bus.o_valid), 64'(q.size() > 0));
            chk("i_ready", 64'(bus.i_ready), 64'(q.size() < 2));
            chk("o_sync_error", 64'(bus.o_sync_error), 64'(exp_sync));
            chk("o_drop_count", 64'(bus.o_drop_count), 64'(exp_drop));
            if (q.size() > 0) begin
                chk("o_frame", bus.o_frame, q[0]);
                if (bus.o_ready) begin
                    void'(q.pop_front());
                    handshakes++;
                end
            end
        end
    end

    initial begin
        logic [63:0] f;
        int ch;
        reset = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_channel = '0;
        bus.i_audio = '0;
        bus.o_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Basic frame
        send_frame(64'h4444_3333_2222_1111, 1'b1);
        cyc(1'b0, 0, '0, 1'b1);
        cyc(1'b0, 0, '0, 1'b1);

        // Streaming: three frames back to back
        for (int n = 0; n < 3; n++) begin
            f = {$urandom, $urandom};
            send_frame(f, 1'b1);
        end
        cyc(1'b0, 0, '0, 1'b1);

        // Backpressure: A and B held, C ch0 offered while blocked
        send_frame(64'hA004_A003_A002_A001, 1'b0);
        send_frame(64'hB004_B003_B002_B001, 1'b0);
        cyc(1'b1, 0, 16'hC001, 1'b0);
        cyc(1'b1, 0, 16'hC001, 1'b1);
        cyc(1'b0, 0, '0, 1'b0);
        send_frame(64'hC004_C003_C002_C001, 1'b1);
        repeat (3) cyc(1'b0, 0, '0, 1'b1);

        // Resync on channel 0
        cyc(1'b1, 0, 16'h0101, 1'b1);
        cyc(1'b1, 1, 16'h0202, 1'b1);
        cyc(1'b1, 0, 16'hAAAA, 1'b1);
        cyc(1'b1, 1, 16'hBBBB, 1'b1);
        cyc(1'b1, 2, 16'hCCCC, 1'b1);
        cyc(1'b1, 3, 16'hDDDD, 1'b1);
        cyc(1'b0, 0, '0, 1'b1);

        // Stray sample, then a normal frame
        cyc(1'b1, 2, 16'hEEEE, 1'b1);
        send_frame(64'h0D0D_0C0C_0B0B_0A0A, 1'b1);
        cyc(1'b0, 0, '0, 1'b1);

        // Reset while pending
        send_frame(64'h1234_5678_9ABC_DEF0, 1'b0);
        send_frame(64'h0FED_CBA9_8765_4321, 1'b0);
        cyc(1'b1, 0, 16'h5555, 1'b0);
        do_reset();
        send_frame(64'h7777_6666_5555_4444, 1'b1);
        cyc(1'b0, 0, '0, 1'b1);

        // Random traffic, mostly in order
        for (int n = 0; n < 1500; n++) begin
            ch = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, CH - 1)) : exp_ch;
            cyc($urandom_range(0, 3) != 0, ch, AW'($urandom), $urandom_range(0, 9) < 7);
        end

        repeat (6) cyc(1'b0, 0, '0, 1'b1);
        chk("drained", 64'(q.size()), 64'd0);
        checks++;
        if (handshakes < 20) begin
            errors++;
            $display("FAIL handshakes: got %0d expected at least 20", handshakes);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/multichannel_audio_parallelizer.md
# multichannel_audio_parallelizer

Collects a serial, channel-tagged audio sample stream into complete parallel frames of `channels` samples and emits each frame on one wide valid/ready output bus. It is the N-channel, double-buffered successor to the stereo-only parallelizer. Typical placement is between a serial audio receiver or deserializer and frame-oriented DSP such as echo/delay or mixing stages. It adds channel-order checking with resynchronisation, and input acceptance while a previous frame waits downstream.

## Interface
- `audio_width`, default 32: bits per sample.
- `channels`, default 2: samples per frame; must be ≥ 2.
- `cw` (localparam): `$clog2(channels)`; index width.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `i_valid`  in  1  input sample valid.
- `i_ready`  out  1  block can accept a sample this cycle.
- `i_channel`  in  cw  channel index of `i_audio`.
- `i_audio`  in  audio_width  sample.
- `o_valid`  out  1  `o_frame` holds a complete frame.
- `o_ready`  in  1  downstream accepts the frame.
- `o_frame`  out  channels*audio_width  channel k occupies bits `[k*audio_width +: audio_width]`.
- `o_sync_error`  out  1  one-cycle pulse per out-of-order sample.
- `o_drop_count`  out  16  saturating count of discarded partial frames and stray samples.

## Operation
- **Storage:**
  - Assembly register: `channels` × `audio_width`.
  - Output register: `o_frame`.
  - Expected-channel counter `exp`, range 0..channels-1.
  - `pending` flag.
- **Accept:** a sample is accepted when `i_valid && i_ready`. `i_ready = !pending`.
- **In-order sample** (`i_channel == exp`):
  - Written into assembly slot `exp`.
  - `exp` increments; it wraps to 0 after `channels-1`.
- **Frame complete:** an in-order sample with `exp == channels-1` completes the frame.
  - Output free (`!o_valid || o_ready` this cycle): the whole frame, including the current sample, loads into `o_frame` and `o_valid` is set to 1.
  - Otherwise: `pending` is set to 1 and the frame stays in the assembly register.
- **Pending drain:** while `pending`, on `o_valid && o_ready` the assembly frame loads into `o_frame`, `o_valid` stays 1 and `pending` clears.
- **Output drain:** on `o_valid && o_ready` with no load in the same cycle, `o_valid` clears.
- **Out-of-order sample** (`i_channel != exp`, including `i_channel ≥ channels`):
  - `o_sync_error` pulses for 1 cycle.
  - If `i_channel == 0`: the partial frame is discarded, the sample is written to slot 0 and `exp` becomes 1. `o_drop_count` increments only if `exp != 0`.
  - Otherwise: the sample is dropped, `exp` becomes 0 and `o_drop_count` increments.
- **Drop counter:** saturates at 16'hFFFF.
- **Assembly slots:** never cleared on discard; they are overwritten by later samples.

## Timing
- **Reset values** (async, immediate):
  - `i_ready` = 1, `o_valid` = 0, `o_frame` = 0, `o_sync_error` = 0, `o_drop_count` = 0.
  - `exp` = 0, `pending` = 0, assembly register = 0.
- **Latency:** last sample accepted at edge t → `o_valid` = 1 and `o_frame` updated after edge t, i.e. visible in cycle t+1.
- **Throughput:** one sample per clock with no bubbles while `o_ready` is held high.
  - Back-to-back frames: `o_valid` stays high and `o_frame` changes every `channels` cycles.
- **Backpressure:** `i_ready` drops the cycle after the frame-completing sample is accepted while output is occupied and not being drained. It returns to 1 the cycle after the output handshake.
- **Handshake stability:** `o_frame` is stable while `o_valid && !o_ready`.
- **Same-cycle output handshake and frame completion:** the new frame loads and `o_valid` remains 1; no cycle gap.
- **Reset mid-frame or mid-pending:**
  - All state is lost.
  - No partial frame is ever emitted.
  - `o_drop_count` is not incremented by reset.
- **`o_sync_error` registration:** registered, high exactly the cycle after the offending accept.

## Test plan
- **Basic 4-channel:** `channels`=4, `audio_width`=16; send ch0..3 = 16'h1111, 2222, 3333, 4444 with `o_ready`=1 → `o_frame`=64'h4444_3333_2222_1111 with `o_valid` high for 1 cycle, one cycle after the ch3 accept; `o_sync_error` never asserts.
- **Streaming:** `channels`=2; 3 frames back-to-back, `o_ready`=1 → 3 handshakes; `i_ready` constantly 1.
- **Backpressure:** `channels`=2; `o_ready`=0; send frames A and B.
  - After B's last sample: `i_ready`=0 and `o_frame`=A.
  - Raise `o_ready` for 1 cycle → `o_frame`=B next cycle, `o_valid` stays 1, `i_ready`=1.
  - Frame C's ch0 is not accepted while `i_ready`=0.
- **Resync on ch0:** `channels`=4; send ch0, ch1, ch0(=16'hAAAA), ch1, ch2, ch3.
  - One `o_sync_error` pulse; `o_drop_count`=1.
  - Emitted frame has slot 0 = 16'hAAAA.
- **Stray sample:** send ch2 first → `o_sync_error` pulse, `o_drop_count`=1, no write; then ch0..3 → a normal frame is emitted.
- **Reset mid-pending:** assert `reset` while `pending`=1 and `o_valid`=1 → all outputs return to reset values; the next full frame is emitted normally.
